// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared sample types and attenuation codes for the echo path.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Each step is one arithmetic right shift, i.e. roughly 6 dB.
    localparam logic [1:0] ATT_0DB  = 2'd0;
    localparam logic [1:0] ATT_6DB  = 2'd1;
    localparam logic [1:0] ATT_12DB = 2'd2;
    localparam logic [1:0] ATT_18DB = 2'd3;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_DRY  = 2'd1,
        SRC_RAM  = 2'd2
    } out_src_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_ram
//  Description : Simple dual-port RAM, one write port, one registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : sdp_ram
`default_nettype wire

// File: rtl/echo_delay.sv
`default_nettype none
// ============================================================================
//  Module      : echo_delay
//  Description : Programmable circular-buffer delay line with attenuated output.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_delay
    import audio_pkg::*;
#(
    parameter int WIDTH  = SAMPLE_W,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic [ADDR_W-1:0]       delay,
    input  logic [1:0]              atten,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] delayed_out
);

    localparam logic [ADDR_W-1:0] c_FILL_MAX = '1;
    localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

    logic [ADDR_W-1:0]       r_wr_ptr;
    logic [ADDR_W-1:0]       r_fill;
    logic                    r_out_valid;
    out_src_t                r_src;
    logic signed [WIDTH-1:0] r_dry;
    logic [1:0]              r_atten;

    logic                    w_accept;
    logic [ADDR_W-1:0]       w_rd_addr;
    logic                    w_bypass;
    logic                    w_hit;
    logic [WIDTH-1:0]        w_ram_q;
    logic signed [WIDTH-1:0] w_pre;

    // A sample arriving together with clear is dropped entirely.
    assign w_accept  = in_valid & ~clear;
    assign w_rd_addr = r_wr_ptr - delay;
    assign w_bypass  = (delay == '0);
    assign w_hit     = (r_fill >= delay);

    sdp_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (sample_in),
        .i_rd_en   (w_accept),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_src       <= SRC_ZERO;
            r_dry       <= '0;
            r_atten     <= ATT_0DB;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_src       <= SRC_ZERO;
            r_dry       <= '0;
            r_atten     <= ATT_0DB;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
                if (r_fill != c_FILL_MAX) begin
                    r_fill <= r_fill + c_ONE;
                end
                r_dry   <= sample_in;
                r_atten <= atten;
                // Zero delay would read the slot being written; take the dry sample instead.
                if (w_bypass) begin
                    r_src <= SRC_DRY;
                end else if (w_hit) begin
                    r_src <= SRC_RAM;
                end else begin
                    r_src <= SRC_ZERO;
                end
            end
        end
    end

    // RAM read data and selection registers only change on accepted strobes,
    // so the output holds between strobes without a further register stage.
    always_comb begin
        w_pre = '0;
        case (r_src)
            SRC_DRY:  w_pre = r_dry;
            SRC_RAM:  w_pre = $signed(w_ram_q);
            default:  w_pre = '0;
        endcase
    end

    always_comb begin
        delayed_out = w_pre;
        case (r_atten)
            ATT_0DB:  delayed_out = w_pre;
            ATT_6DB:  delayed_out = w_pre >>> 1;
            ATT_12DB: delayed_out = w_pre >>> 2;
            ATT_18DB: delayed_out = w_pre >>> 3;
            default:  delayed_out = w_pre;
        endcase
    end

    assign out_valid = r_out_valid;

endmodule : echo_delay
`default_nettype wire

// File: tb/tb_echo_delay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_delay
//  Description : Directed self-checking bench for echo_delay (8-entry buffer).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_delay;

    localparam int W  = 16;
    localparam int AW = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear;
    logic                 in_valid;
    logic signed [W-1:0]  sample_in;
    logic [AW-1:0]        delay;
    logic [1:0]           atten;
    logic                 out_valid;
    logic signed [W-1:0]  delayed_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    echo_delay #(
        .WIDTH  (W),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .sample_in   (sample_in),
        .delay       (delay),
        .atten       (atten),
        .out_valid   (out_valid),
        .delayed_out (delayed_out)
    );

    task automatic send(input logic signed [W-1:0] s, input logic [AW-1:0] d,
                        input logic [1:0] a, output logic v, output logic signed [W-1:0] o);
        @(negedge clk);
        clear     = 1'b0;
        in_valid  = 1'b1;
        sample_in = s;
        delay     = d;
        atten     = a;
        @(posedge clk);
        #1;
        v = out_valid;
        o = delayed_out;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        sample_in = '0; delay = '0; atten = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || delayed_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL reset_hold: out_valid=%0b delayed_out=%0d, want 0/0", out_valid, delayed_out);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || delayed_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL reset_release: out_valid=%0b delayed_out=%0d, want 0/0", out_valid, delayed_out);
        end
    endtask

    task automatic test_warmup();
        int exp_o [7] = '{0, 0, 0, 0, 1, 2, 3};
        logic v;
        logic signed [W-1:0] o;
        for (int i = 0; i < 7; i++) begin
            send(W'(i + 1), 3'd4, 2'd0, v, o);
            n_cmp++;
            if (v !== 1'b1 || o !== exp_o[i]) begin
                n_bad++;
                $display("FAIL warmup[%0d]: valid=%0b out=%0d, want 1/%0d", i, v, o, exp_o[i]);
            end
        end
        idle();
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || delayed_out !== 16'sd3) begin
            n_bad++;
            $display("FAIL warmup_hold: valid=%0b out=%0d, want 0/3", out_valid, delayed_out);
        end
    endtask

    task automatic test_bypass();
        logic v;
        logic signed [W-1:0] o;
        send(-16'sd100, 3'd0, 2'd1, v, o);
        n_cmp++;
        if (v !== 1'b1 || o !== -16'sd50) begin
            n_bad++;
            $display("FAIL bypass_neg: valid=%0b out=%0d, want 1/-50", v, o);
        end
        send(16'sh7FFF, 3'd0, 2'd1, v, o);
        n_cmp++;
        if (v !== 1'b1 || o !== 16'sh3FFF) begin
            n_bad++;
            $display("FAIL bypass_max: valid=%0b out=%h, want 1/3fff", v, o);
        end
        idle();
    endtask

    task automatic test_wrap();
        logic v;
        logic signed [W-1:0] o;
        int e;
        do_clear();
        for (int k = 0; k < 20; k++) begin
            send(W'(k), 3'd7, 2'd0, v, o);
            e = (k >= 7) ? k - 7 : 0;
            n_cmp++;
            if (v !== 1'b1 || o !== e) begin
                n_bad++;
                $display("FAIL wrap[%0d]: valid=%0b out=%0d, want 1/%0d", k, v, o, e);
            end
        end
        idle();
    endtask

    task automatic test_atten_sign();
        int exp_o [3] = '{0, 0, -1};
        logic v;
        logic signed [W-1:0] o;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            send(-16'sd8, 3'd2, 2'd3, v, o);
            n_cmp++;
            if (v !== 1'b1 || o !== exp_o[i]) begin
                n_bad++;
                $display("FAIL atten_sign[%0d]: valid=%0b out=%0d, want 1/%0d", i, v, o, exp_o[i]);
            end
        end
        send(16'sd0, 3'd2, 2'd0, v, o);
        n_cmp++;
        if (v !== 1'b1 || o !== -16'sd8) begin
            n_bad++;
            $display("FAIL atten_stored: valid=%0b out=%0d, want 1/-8", v, o);
        end
        idle();
    endtask

    task automatic test_delay_change();
        logic v;
        logic signed [W-1:0] o;
        int e;
        do_clear();
        for (int k = 0; k < 10; k++) begin
            send(W'(100 + k), 3'd5, 2'd0, v, o);
            e = (k >= 5) ? 100 + k - 5 : 0;
            n_cmp++;
            if (v !== 1'b1 || o !== e) begin
                n_bad++;
                $display("FAIL delay5[%0d]: valid=%0b out=%0d, want 1/%0d", k, v, o, e);
            end
        end
        idle();
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL delay_gap: valid=%0b, want 0", out_valid);
        end
        send(16'sd110, 3'd2, 2'd0, v, o);
        n_cmp++;
        if (v !== 1'b1 || o !== 16'sd108) begin
            n_bad++;
            $display("FAIL delay2: valid=%0b out=%0d, want 1/108", v, o);
        end
        idle();
    endtask

    task automatic test_clear();
        int exp_o [4] = '{0, 0, 0, 1};
        logic v;
        logic signed [W-1:0] o;
        @(negedge clk);
        clear     = 1'b1;
        in_valid  = 1'b1;
        sample_in = 16'sd55;
        delay     = 3'd3;
        atten     = 2'd0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || delayed_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL clear_drop: valid=%0b out=%0d, want 0/0", out_valid, delayed_out);
        end
        for (int i = 0; i < 4; i++) begin
            send(W'(i + 1), 3'd3, 2'd0, v, o);
            n_cmp++;
            if (v !== 1'b1 || o !== exp_o[i]) begin
                n_bad++;
                $display("FAIL clear_resume[%0d]: valid=%0b out=%0d, want 1/%0d", i, v, o, exp_o[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic v;
        logic signed [W-1:0] o;
        send(16'sd9, 3'd1, 2'd0, v, o);
        n_cmp++;
        if (v !== 1'b1 || o !== 16'sd4) begin
            n_bad++;
            $display("FAIL pre_reset: valid=%0b out=%0d, want 1/4", v, o);
        end
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || delayed_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%0b out=%0d, want 0/0", out_valid, delayed_out);
        end
        @(negedge clk);
        reset = 1'b0;
        send(16'sd5, 3'd1, 2'd0, v, o);
        n_cmp++;
        if (v !== 1'b1 || o !== 16'sd0) begin
            n_bad++;
            $display("FAIL post_reset0: valid=%0b out=%0d, want 1/0", v, o);
        end
        send(16'sd6, 3'd1, 2'd0, v, o);
        n_cmp++;
        if (v !== 1'b1 || o !== 16'sd5) begin
            n_bad++;
            $display("FAIL post_reset1: valid=%0b out=%0d, want 1/5", v, o);
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_warmup();
        test_bypass();
        test_wrap();
        test_atten_sign();
        test_delay_change();
        test_clear();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_echo_delay
`default_nettype wire

// File: doc/echo_delay.md
Name: echo_delay

Overview:
- Circular-buffer delay line producing the delayed, attenuated "wet" sample for the echo path.
- Sits directly upstream of the WIDTH-bit two-input adder.
- Dry sample feeds adder input a; this block's delayed_out feeds adder input b; the adder sums them combinationally.
- Advances one slot per input sample strobe. The delay is programmable in samples at run time.

Parameters:
- WIDTH, 16: sample width, two's-complement; must match the adder WIDTH.
- ADDR_W, 10: buffer address width; DEPTH = 2**ADDR_W samples; maximum delay is DEPTH-1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush: zeroes the pointer and fill count, masking the old buffer contents.
- in_valid  input  1  one-cycle strobe; sample_in is valid this cycle.
- sample_in  input  WIDTH  dry sample, signed.
- delay  input  ADDR_W  echo delay in samples, 0..DEPTH-1; sampled on each in_valid.
- atten  input  2  attenuation; output = delayed sample arithmetic-shifted right by atten (0, 6, 12 or 18 dB).
- out_valid  output  1  one-cycle strobe; delayed_out updated this cycle.
- delayed_out  output  WIDTH  delayed, attenuated sample, signed; held between strobes.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous, active-high.
- Reset state: wr_ptr=0, fill=0, out_valid=0, delayed_out=0. RAM contents are not cleared; fill masks stale data.
- State:
  - wr_ptr: ADDR_W bits, wraps DEPTH-1 -> 0.
  - fill: ADDR_W bits, counts samples written, saturates at DEPTH-1.
- On an in_valid cycle n:
  - rd_addr = wr_ptr - delay, modulo DEPTH (ADDR_W-bit wrap-around subtraction).
  - Write mem[wr_ptr] = sample_in.
  - wr_ptr increments.
  - fill increments unless already DEPTH-1.
  - delay, atten and the hit/bypass decision are registered for the output stage.
- Output stage, cycle n+1:
  - out_valid=1 for exactly one cycle.
  - If delay==0: delayed_out = sample_in (registered at n) >>> atten. This bypass avoids the read/write collision.
  - Else if fill (value before the increment at n) >= delay: delayed_out = mem[rd_addr] >>> atten.
  - Else (warm-up): delayed_out = 0.
- RAM: synchronous read with 1-cycle read latency, so end-to-end latency is fixed at 1 cycle. The RAM read port may be registered; delayed_out itself is then the shift of the RAM output and is held by an output register.
- Arithmetic: shift is arithmetic (sign-preserving). Full WIDTH is kept; no rounding.
- Back-to-back: in_valid may assert on consecutive cycles; one output per input, none dropped.
- Delay change mid-stream: takes effect on the next in_valid. No flush is performed; warm-up masking is re-evaluated against the new delay using the current fill.
- clear: synchronous, behaves like reset for wr_ptr, fill, out_valid and delayed_out.
  - clear has priority over a simultaneous in_valid: that sample is dropped and no out_valid follows.
- Reset mid-operation: any pending out_valid is cancelled immediately.
- fill saturation: once fill=DEPTH-1, every legal delay reads written data; fill stays saturated until reset or clear.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W = 16.
  - Signed sample typedef sample_t.
  - Attenuation encoding constants ATT_0DB..ATT_18DB.
- Sub-module sdp_ram (simple dual-port, one write port, one synchronous read port):
  - Parameterised by WIDTH and ADDR_W; infers block RAM.
  - echo_delay instantiates one.

Test Plan:
- Reset then warm-up:
  - Stimulus: delay=4, atten=0, samples 1,2,3,...
  - Response: outputs 0,0,0,0,1,2,3, each out_valid exactly 1 cycle after in_valid.
- Bypass:
  - Stimulus: delay=0, atten=1, sample_in=-100.
  - Response: delayed_out=-50 next cycle. Then sample_in=16'h7FFF gives 16'h3FFF.
- Wrap-around:
  - Stimulus: ADDR_W=3, delay=7, 20 back-to-back strobes of values 0..19.
  - Response: output k = k-7 for k>=7, else 0. Pointer wraps cleanly at 8.
- Attenuation sign:
  - Stimulus: delay=2, atten=3, samples -8,-8,-8.
  - Response: third output = -1. Stored value -8 is unchanged for atten=0 reads.
- Delay change mid-stream:
  - Stimulus: buffer full, delay switched 5 -> 2 between strobes.
  - Response: the next output is the sample from 2 strobes earlier, with no glitch strobe.
- Clear and reset interaction:
  - Stimulus: clear with in_valid in the same cycle, then resume.
  - Response: no out_valid that cycle; next outputs 0 until fill>=delay.
  - Stimulus: async reset asserted mid-stream between edges.
  - Response: out_valid and delayed_out go to 0 immediately.
